uc_heartbeat_tx: RTL and testbench

- Processor-side heartbeat emitter; one instance per microcontroller.
- Drives the mon1/mon2 monitor lines and the errorUC flag consumed by the dual-processor selector.
- Obeys the selector's resetuC request by sequencing the core reset.
- Turns software "alive" kicks and self-test faults into a quadrature heartbeat or a latched error.

---
 rtl/uc_heartbeat_tx.sv | 146 ++++++++++++++
 tb/tb_uc_heartbeat_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uc_heartbeat_tx.sv
// Processor-side heartbeat emitter: sequences core reset, boots, then drives a
// quadrature heartbeat on mon1/mon2 or latches error_uc. Optional: UC_HB_FAULT_COUNT_EN.
module uc_heartbeat_tx #(
   parameter int PERIOD       = 16,
   parameter int KICK_TIMEOUT = 64,
   parameter int RST_HOLD     = 8,
   parameter int BOOT_CYCLES  = 32,
   parameter int CW           = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       kick,
   input  logic       fault_in,
   input  logic       reset_req,
   output logic       mon1,
   output logic       mon2,
   output logic       error_uc,
   output logic       core_rst_n,
`ifdef UC_HB_FAULT_COUNT_EN
   output logic [7:0] fault_count,
`endif
   output logic [1:0] state
);

   localparam logic [1:0] S_RST_HOLD = 2'b00;
   localparam logic [1:0] S_BOOT     = 2'b01;
   localparam logic [1:0] S_RUN      = 2'b10;
   localparam logic [1:0] S_FAULT    = 2'b11;

   localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD - 1);
   localparam logic [CW-1:0] BOOT_LAST = CW'(BOOT_CYCLES - 1);
   localparam logic [CW-1:0] HB_LAST   = CW'(PERIOD - 1);
   localparam logic [CW-1:0] HB_MID    = CW'(PERIOD / 2 - 1);
   localparam logic [CW-1:0] KICK_LAST = CW'(KICK_TIMEOUT - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] phase_cnt;   // hold_cnt in RST_HOLD, boot_cnt in BOOT
   logic [CW-1:0] hb_cnt, kick_cnt;
   logic          mon1_d, mon2_d, error_d, core_d;
   logic          stay_run;

   assign state    = state_q;
   assign stay_run = (state_q == S_RUN) && (state_d == S_RUN);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_RST_HOLD;
      else        state_q <= state_d;
   end

   // Priority: reset_req > fault_in > kick timeout.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RST_HOLD: if (!reset_req && phase_cnt == HOLD_LAST) state_d = S_BOOT;
         S_BOOT: begin
            if (reset_req)                   state_d = S_RST_HOLD;
            else if (fault_in)               state_d = S_FAULT;
            else if (phase_cnt == BOOT_LAST) state_d = S_RUN;
         end
         S_RUN: begin
            if (reset_req)                          state_d = S_RST_HOLD;
            else if (fault_in)                      state_d = S_FAULT;
            else if (!kick && kick_cnt == KICK_LAST) state_d = S_FAULT;
         end
         S_FAULT: if (reset_req) state_d = S_RST_HOLD;
         default: state_d = S_RST_HOLD;
      endcase
   end

   // Next values of the registered outputs; lines freeze on the edge that leaves RUN.
   always_comb begin
      mon1_d  = mon1;
      mon2_d  = mon2;
      error_d = (state_d == S_FAULT);
      core_d  = (state_d != S_RST_HOLD);
      case (state_d)
         S_RST_HOLD, S_BOOT: begin
            mon1_d = 1'b0;
            mon2_d = 1'b0;
         end
         S_RUN: begin
            if (state_q == S_RUN) begin
               mon1_d = mon1 ^ (hb_cnt == HB_LAST);
               mon2_d = mon2 ^ (hb_cnt == HB_MID);
            end
         end
         default: begin
            mon1_d = mon1;
            mon2_d = mon2;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mon1       <= 1'b0;
         mon2       <= 1'b0;
         error_uc   <= 1'b0;
         core_rst_n <= 1'b0;
      end else begin
         mon1       <= mon1_d;
         mon2       <= mon2_d;
         error_uc   <= error_d;
         core_rst_n <= core_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         phase_cnt <= '0;
         hb_cnt    <= '0;
         kick_cnt  <= '0;
      end else begin
         if (state_d != state_q)
            phase_cnt <= '0;
         else if (state_q == S_RST_HOLD)
            phase_cnt <= reset_req ? '0 : phase_cnt + CW'(1);
         else if (state_q == S_BOOT)
            phase_cnt <= phase_cnt + CW'(1);
         else
            phase_cnt <= '0;

         if (stay_run) begin
            hb_cnt   <= (hb_cnt == HB_LAST) ? '0 : hb_cnt + CW'(1);
            kick_cnt <= kick ? '0 : kick_cnt + CW'(1);
         end else begin
            hb_cnt   <= '0;
            kick_cnt <= '0;
         end
      end
   end

`ifdef UC_HB_FAULT_COUNT_EN
   logic [7:0] fault_cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         fault_cnt <= 8'd0;
      else if (state_d == S_FAULT && (state_q == S_RUN || state_q == S_BOOT) && fault_cnt != 8'hFF)
         fault_cnt <= fault_cnt + 8'd1;
   end

   assign fault_count = fault_cnt;
`endif

endmodule

// File: tb/tb_uc_heartbeat_tx.sv
// Bench for uc_heartbeat_tx: directed vector table, async reset check, and
// randomized traffic against a time-based reference model.
module tb_uc_heartbeat_tx;

   localparam int PERIOD       = 16;
   localparam int KICK_TIMEOUT = 64;
   localparam int RST_HOLD     = 8;
   localparam int BOOT_CYCLES  = 32;
   localparam int CW           = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       kick = 1'b0;
   logic       fault_in = 1'b0;
   logic       reset_req = 1'b0;
   logic       mon1, mon2, error_uc, core_rst_n;
   logic [1:0] state;
`ifdef UC_HB_FAULT_COUNT_EN
   logic [7:0] fault_count;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   uc_heartbeat_tx #(
      .PERIOD(PERIOD), .KICK_TIMEOUT(KICK_TIMEOUT), .RST_HOLD(RST_HOLD),
      .BOOT_CYCLES(BOOT_CYCLES), .CW(CW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .kick       (kick),
      .fault_in   (fault_in),
      .reset_req  (reset_req),
      .mon1       (mon1),
      .mon2       (mon2),
      .error_uc   (error_uc),
      .core_rst_n (core_rst_n),
`ifdef UC_HB_FAULT_COUNT_EN
      .fault_count(fault_count),
`endif
      .state      (state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit         rr;
      bit         f;
      bit         k;
      int         n;
      logic [1:0] st;
      bit         m1;
      bit         m2;
      bit         e;
      bit         c;
      int         fc;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit rr, bit f, bit k, int n, logic [1:0] st,
                               bit m1, bit m2, bit e, bit c, int fc);
      vec_t v;
      v = '{rr, f, k, n, st, m1, m2, e, c, fc};
      tbl.push_back(v);
   endfunction

   // ---------------- reference model ----------------
   // Mode plus elapsed-time counts; heartbeat lines derived from time spent in RUN.
   int m_state;   // 0 hold, 1 boot, 2 run, 3 fault
   int m_low;     // consecutive reset_req-low cycles in hold
   int m_boot;    // cycles spent in boot
   int m_t;       // cycles since RUN entry
   int m_quiet;   // cycles since last kick (or RUN entry)
   bit m_mon1, m_mon2;
   int m_fc;
   logic [5:0] exp_q[$];

   function automatic bit mon1_at(int t);
      return ((t / PERIOD) % 2) == 1;
   endfunction

   function automatic bit mon2_at(int t);
      if (t < PERIOD / 2) return 1'b0;
      return ((((t - PERIOD / 2) / PERIOD) + 1) % 2) == 1;
   endfunction

   task automatic model_reset();
      m_state = 0; m_low = 0; m_boot = 0; m_t = 0; m_quiet = 0;
      m_mon1 = 0; m_mon2 = 0; m_fc = 0;
   endtask

   task automatic model_hold();
      m_state = 0; m_low = 0; m_mon1 = 0; m_mon2 = 0;
   endtask

   task automatic model_fault();
      m_state = 3;
      if (m_fc < 255) m_fc++;
   endtask

   task automatic model_step(input bit rr, input bit f, input bit k);
      int q;
      case (m_state)
         0: begin
            if (rr) m_low = 0;
            else begin
               m_low++;
               if (m_low == RST_HOLD) begin m_state = 1; m_boot = 0; end
            end
         end
         1: begin
            if (rr) model_hold();
            else if (f) model_fault();
            else begin
               m_boot++;
               if (m_boot == BOOT_CYCLES) begin m_state = 2; m_t = 0; m_quiet = 0; end
            end
         end
         2: begin
            q = k ? 0 : m_quiet + 1;
            if (rr) model_hold();
            else if (f) model_fault();
            else if (q == KICK_TIMEOUT) model_fault();
            else begin
               m_quiet = q;
               m_t++;
               m_mon1 = mon1_at(m_t);
               m_mon2 = mon2_at(m_t);
            end
         end
         default: if (rr) model_hold();
      endcase
   endtask

   // ---------------- driver ----------------
   // Called at a negedge: drive, predict, clock once, compare at the next negedge.
   task automatic run_cycle(input bit rr, input bit f, input bit k);
      logic [5:0] exp;
      reset_req = rr; fault_in = f; kick = k;
      model_step(rr, f, k);
      exp_q.push_back({2'(m_state), m_mon1, m_mon2, (m_state == 3), (m_state != 0)});
      @(posedge clk);
      @(negedge clk);
      exp = exp_q.pop_front();
      check("model_state",      state,      exp[5:4]);
      check("model_mon1",       mon1,       exp[3]);
      check("model_mon2",       mon2,       exp[2]);
      check("model_error_uc",   error_uc,   exp[1]);
      check("model_core_rst_n", core_rst_n, exp[0]);
`ifdef UC_HB_FAULT_COUNT_EN
      check("model_fault_count", fault_count, m_fc);
`endif
   endtask

   // ---------------- test sequence ----------------
   initial begin
      int rr_left;
      int kick_div;
      bit rr, f, k;

      //   rr f  k  n   st    m1 m2 e  c  fc
      add(0, 0, 0, 7,  2'b00, 0, 0, 0, 0, 0);
      add(0, 0, 0, 1,  2'b01, 0, 0, 0, 1, 0);
      add(0, 0, 0, 31, 2'b01, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1,  2'b10, 0, 0, 0, 1, 0);
      add(0, 0, 0, 7,  2'b10, 0, 0, 0, 1, 0);
      add(0, 0, 0, 1,  2'b10, 0, 1, 0, 1, 0);
      add(0, 0, 0, 8,  2'b10, 1, 1, 0, 1, 0);
      add(0, 0, 0, 8,  2'b10, 1, 0, 0, 1, 0);
      add(0, 0, 1, 1,  2'b10, 1, 0, 0, 1, 0);
      add(0, 0, 0, 63, 2'b10, 1, 0, 0, 1, 0);
      add(0, 0, 0, 1,  2'b11, 1, 0, 1, 1, 1);
      add(0, 1, 1, 10, 2'b11, 1, 0, 1, 1, 1);
      add(1, 0, 0, 1,  2'b00, 0, 0, 0, 0, 1);
      add(1, 0, 0, 4,  2'b00, 0, 0, 0, 0, 1);
      add(0, 0, 0, 7,  2'b00, 0, 0, 0, 0, 1);
      add(0, 0, 0, 1,  2'b01, 0, 0, 0, 1, 1);
      add(0, 1, 0, 1,  2'b11, 0, 0, 1, 1, 2);
      add(1, 0, 0, 1,  2'b00, 0, 0, 0, 0, 2);
      add(0, 0, 0, 8,  2'b01, 0, 0, 0, 1, 2);
      add(0, 0, 0, 32, 2'b10, 0, 0, 0, 1, 2);
      add(0, 0, 0, 20, 2'b10, 1, 1, 0, 1, 2);
      add(0, 1, 1, 1,  2'b11, 1, 1, 1, 1, 3);
      add(1, 0, 0, 1,  2'b00, 0, 0, 0, 0, 3);
      add(0, 0, 0, 8,  2'b01, 0, 0, 0, 1, 3);
      add(0, 0, 0, 32, 2'b10, 0, 0, 0, 1, 3);
      add(0, 0, 1, 10, 2'b10, 0, 1, 0, 1, 3);
      add(1, 1, 0, 1,  2'b00, 0, 0, 0, 0, 3);

      // reset values
      repeat (2) @(negedge clk);
      check("rst_state",      state,      2'b00);
      check("rst_mon1",       mon1,       1'b0);
      check("rst_mon2",       mon2,       1'b0);
      check("rst_error_uc",   error_uc,   1'b0);
      check("rst_core_rst_n", core_rst_n, 1'b0);
      reset = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         reset_req = tbl[i].rr; fault_in = tbl[i].f; kick = tbl[i].k;
         repeat (tbl[i].n) @(posedge clk);
         @(negedge clk);
         check($sformatf("vec%0d_state", i),      state,      tbl[i].st);
         check($sformatf("vec%0d_mon1", i),       mon1,       tbl[i].m1);
         check($sformatf("vec%0d_mon2", i),       mon2,       tbl[i].m2);
         check($sformatf("vec%0d_error_uc", i),   error_uc,   tbl[i].e);
         check($sformatf("vec%0d_core_rst_n", i), core_rst_n, tbl[i].c);
`ifdef UC_HB_FAULT_COUNT_EN
         check($sformatf("vec%0d_fault_count", i), fault_count, tbl[i].fc);
`endif
      end

      // async reset mid-RUN: 24 cycles into RUN mon1=1, mon2=0
      reset_req = 0; fault_in = 0; kick = 0;
      repeat (RST_HOLD + BOOT_CYCLES + 24) @(posedge clk);
      @(negedge clk);
      check("pre_async_state", state, 2'b10);
      check("pre_async_mon1",  mon1,  1'b1);
      #2 reset = 1'b0;
      #1;
      check("async_state",      state,      2'b00);
      check("async_mon1",       mon1,       1'b0);
      check("async_mon2",       mon2,       1'b0);
      check("async_error_uc",   error_uc,   1'b0);
      check("async_core_rst_n", core_rst_n, 1'b0);
`ifdef UC_HB_FAULT_COUNT_EN
      check("async_fault_count", fault_count, 8'd0);
`endif
      @(negedge clk);
      reset = 1'b1;
      model_reset();

      // kick every 50 clocks for 1000 clocks of RUN: never faults
      for (int c = 0; c < RST_HOLD + BOOT_CYCLES + 1000; c++)
         run_cycle(1'b0, 1'b0, (c >= 50) && (c % 50 == 0));
      check("kick50_state",    state,    2'b10);
      check("kick50_error_uc", error_uc, 1'b0);

      // randomized traffic
      rr_left  = 0;
      kick_div = 12;
      for (int c = 0; c < 3000; c++) begin
         if (c % 500 == 0) begin
            case ($urandom_range(0, 2))
               0:       kick_div = 12;
               1:       kick_div = 40;
               default: kick_div = 90;
            endcase
         end
         if (rr_left == 0 && $urandom_range(0, 249) == 0) rr_left = $urandom_range(1, 6);
         rr = (rr_left > 0);
         if (rr_left > 0) rr_left--;
         f = ($urandom_range(0, 349) == 0);
         k = ($urandom_range(0, kick_div - 1) == 0);
         run_cycle(rr, f, k);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
